// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp codes, phase and direction types for the phase scheduler
package traffic_pkg;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;
    typedef enum logic [2:0] {
        A_GREEN, A_YEL, ALL_RED_1, B_GREEN, B_YEL, ALL_RED_2, PED_WALK, FLASH
    } phase_t;
    typedef enum logic {DIR_A, DIR_B} dir_t;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating tick counter cleared on phase entry, e_o = count + 1
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       tick_i,
    output logic [7:0] cnt_o,
    output logic [8:0] e_o
);
    logic [7:0] cnt_q, cnt_d;
    assign cnt_o = cnt_q;
    assign e_o   = {1'b0, cnt_q} + 9'd1;
    always_comb cnt_d = clr_i ? 8'd0 : (tick_i && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: demand-actuated two-approach phase scheduler with ped walk and night flash
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 8,
    parameter int unsigned YEL_T     = 1,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned WALK_T    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       modo,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       ped_req,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic       walk,
    output logic [7:0] timer
);
    localparam logic [8:0] G_MIN = 9'(GREEN_MIN);
    localparam logic [8:0] G_MAX = 9'(GREEN_MAX);
    localparam logic [8:0] Y_T   = 9'(YEL_T);
    localparam logic [8:0] AR_T  = 9'(ALLRED_T);
    localparam logic [8:0] W_T   = 9'(WALK_T);
    phase_t     st_q, st_d, grn_nx;
    dir_t       dir_q, dir_d;
    logic       pend_q, pend_d, fl_q, fl_d, entry, walk_d;
    logic [2:0] a_d, b_d;
    logic [8:0] e;
    phase_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (entry),
        .tick_i (tick),
        .cnt_o  (timer),
        .e_o    (e)
    );
    assign grn_nx = (dir_q == DIR_A) ? A_GREEN : B_GREEN;
    assign entry  = st_d != st_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            st_q   <= A_GREEN;
            dir_q  <= DIR_B;
            pend_q <= 1'b0;
            fl_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            dir_q  <= dir_d;
            pend_q <= pend_d;
            fl_q   <= fl_d;
        end
    always_comb begin
        st_d = st_q;
        case (st_q)
            A_GREEN:   if (tick && (req_b || pend_q) && ((e >= G_MIN && !req_a) || e >= G_MAX)) st_d = A_YEL;
            A_YEL:     if (tick && e == Y_T) st_d = ALL_RED_1;
            B_GREEN:   if (tick && (req_a || pend_q) && ((e >= G_MIN && !req_b) || e >= G_MAX)) st_d = B_YEL;
            B_YEL:     if (tick && e == Y_T) st_d = ALL_RED_2;
            ALL_RED_1,
            ALL_RED_2: if (tick && e == AR_T) st_d = modo ? FLASH : pend_q ? PED_WALK : grn_nx;
            PED_WALK:  if (tick && e == W_T) st_d = grn_nx;
            FLASH:     if (tick && !modo) st_d = ALL_RED_2;
            default:   st_d = A_GREEN;
        endcase
    end
    // next_dir flips on all-red entry, so leaving FLASH via ALL_RED_2 lands on A
    always_comb begin
        dir_d  = (entry && st_d == ALL_RED_1) ? DIR_B : (entry && st_d == ALL_RED_2) ? DIR_A : dir_q;
        pend_d = (entry && st_d == PED_WALK) ? 1'b0 : pend_q | ped_req;
        fl_d   = (st_q != FLASH) ? 1'b0 : tick ? !fl_q : fl_q;
    end
    always_comb begin
        a_d    = (st_d == A_GREEN) ? GRN : (st_d == A_YEL) ? YEL : (st_d == FLASH) ? (fl_d ? OFF : YEL) : RED;
        b_d    = (st_d == B_GREEN) ? GRN : (st_d == B_YEL) ? YEL : (st_d == FLASH) ? (fl_d ? OFF : YEL) : RED;
        walk_d = st_d == PED_WALK;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            A    <= GRN;
            B    <= RED;
            walk <= 1'b0;
        end else begin
            A    <= a_d;
            B    <= b_d;
            walk <= walk_d;
        end
endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb_traffic_phase_sched: directed vectors with hand-computed lamp/timer expectations
module tb_traffic_phase_sched;
    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, modo = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0, ped_req = 1'b0;
    logic [2:0] A, B;
    logic       walk;
    logic [7:0] timer;
    int         n_chk = 0, n_fail = 0;
    traffic_phase_sched dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .modo    (modo),
        .req_a   (req_a),
        .req_b   (req_b),
        .ped_req (ped_req),
        .A       (A),
        .B       (B),
        .walk    (walk),
        .timer   (timer)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step_tick(input int gap);
        repeat (gap) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step_tick(3);
    endtask
    task automatic do_reset();
        @(negedge clk);
        {modo, req_a, req_b, ped_req, tick} = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic lamps(input string tag, input logic [2:0] ea, input logic [2:0] eb, input logic ew);
        check({tag, ".A"}, 32'(A), 32'(ea));
        check({tag, ".B"}, 32'(B), 32'(eb));
        check({tag, ".walk"}, 32'(walk), 32'(ew));
    endtask
    initial begin
        repeat (2) @(negedge clk);
        lamps("rst", 3'b001, 3'b100, 1'b0);
        check("rst.timer", 32'(timer), 0);
        reset = 1'b0;
        // gap-out after GREEN_MIN
        req_b = 1'b1;
        ticks(3);
        lamps("t1.green3", 3'b001, 3'b100, 1'b0);
        check("t1.timer3", 32'(timer), 3);
        ticks(1);
        lamps("t1.yel", 3'b010, 3'b100, 1'b0);
        check("t1.timer_clr", 32'(timer), 0);
        ticks(1);
        lamps("t1.allred", 3'b100, 3'b100, 1'b0);
        ticks(1);
        lamps("t1.bgreen", 3'b100, 3'b001, 1'b0);
        // rest in green and timer saturation
        do_reset();
        ticks(20);
        lamps("t2.rest20", 3'b001, 3'b100, 1'b0);
        check("t2.timer20", 32'(timer), 20);
        for (int i = 0; i < 240; i++) step_tick(0);
        check("t2.timer_sat", 32'(timer), 255);
        lamps("t2.rest260", 3'b001, 3'b100, 1'b0);
        // max-out with both approaches requesting
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        ticks(4);
        lamps("t3.green4", 3'b001, 3'b100, 1'b0);
        ticks(3);
        lamps("t3.green7", 3'b001, 3'b100, 1'b0);
        ticks(1);
        lamps("t3.yel", 3'b010, 3'b100, 1'b0);
        // pedestrian pulse inserts walk before B green
        do_reset();
        req_b = 1'b1;
        ticks(2);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        ticks(2);
        lamps("t4.yel", 3'b010, 3'b100, 1'b0);
        ticks(1);
        lamps("t4.allred", 3'b100, 3'b100, 1'b0);
        ticks(1);
        lamps("t4.walk1", 3'b100, 3'b100, 1'b1);
        ticks(2);
        lamps("t4.walk3", 3'b100, 3'b100, 1'b1);
        ticks(1);
        lamps("t4.bgreen", 3'b100, 3'b001, 1'b0);
        ticks(10);
        lamps("t4.brest", 3'b100, 3'b001, 1'b0);
        // night flash entered at all-red end, left via ALL_RED_2 to A
        do_reset();
        modo = 1'b1;
        req_b = 1'b1;
        ticks(4);
        lamps("t5.yel", 3'b010, 3'b100, 1'b0);
        ticks(1);
        lamps("t5.allred", 3'b100, 3'b100, 1'b0);
        ticks(1);
        lamps("t5.flash0", 3'b010, 3'b010, 1'b0);
        ticks(1);
        lamps("t5.flash1", 3'b000, 3'b000, 1'b0);
        ticks(1);
        lamps("t5.flash2", 3'b010, 3'b010, 1'b0);
        modo = 1'b0;
        ticks(1);
        lamps("t5.allred2", 3'b100, 3'b100, 1'b0);
        ticks(1);
        lamps("t5.agreen", 3'b001, 3'b100, 1'b0);
        // asynchronous reset during B_GREEN drops pending ped request
        do_reset();
        req_b = 1'b1;
        ticks(6);
        lamps("t6.bgreen", 3'b100, 3'b001, 1'b0);
        req_b = 1'b0;
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        lamps("t6.async", 3'b001, 3'b100, 1'b0);
        check("t6.timer", 32'(timer), 0);
        @(negedge clk);
        reset = 1'b0;
        ticks(6);
        lamps("t6.nopend", 3'b001, 3'b100, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
